// File: rtl/alu_issue_if.sv
// EX-side bundle driven by the ID/EX issue register toward the ALU.
// master = issue stage, slave = ALU / branch / store consumers.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [3:0]      ex_ALUctl;
    logic [XLEN-1:0] ex_A;
    logic [XLEN-1:0] ex_B;
    logic [4:0]      ex_rd;
    logic            ex_is_branch;
    logic            ex_branch_ne;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_illegal;

    modport master (
        output ex_valid, ex_ALUctl, ex_A, ex_B, ex_rd,
        output ex_is_branch, ex_branch_ne, ex_store_data, ex_illegal
    );
    modport slave (
        input ex_valid, ex_ALUctl, ex_A, ex_B, ex_rd,
        input ex_is_branch, ex_branch_ne, ex_store_data, ex_illegal
    );
endinterface

// File: rtl/alu_issue.sv
// ID/EX issue stage: decode, operand select/forward, EX register.
// Optional MEM/WB forwarding muxes: define ALU_ISSUE_FORWARDING_EN.
module alu_issue #(
    parameter int         XLEN        = 32,
    parameter logic [3:0] ILLEGAL_CTL = 4'd15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            stall,
    input  logic            flush,
    input  logic            fwd_mem_en,
    input  logic            fwd_wb_en,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    alu_issue_if.master     ex
);
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;

    assign w_op  = id_instr[6:0];
    assign w_f3  = id_instr[14:12];
    assign w_f7  = id_instr[31:25];
    assign w_rs1 = id_instr[19:15];
    assign w_rs2 = id_instr[24:20];

    logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
    assign w_is_r  = (w_op == 7'b0110011);
    assign w_is_i  = (w_op == 7'b0010011);
    assign w_is_ld = (w_op == 7'b0000011);
    assign w_is_st = (w_op == 7'b0100011);
    assign w_is_br = (w_op == 7'b1100011);

    logic       w_f3_ok;
    logic [3:0] w_f3_ctl;

    always_comb begin
        w_f3_ok  = 1'b1;
        w_f3_ctl = ILLEGAL_CTL;
        unique case (w_f3)
            3'b000:  w_f3_ctl = 4'd2;
            3'b111:  w_f3_ctl = 4'd0;
            3'b110:  w_f3_ctl = 4'd1;
            3'b010:  w_f3_ctl = 4'd7;
            default: w_f3_ok  = 1'b0;
        endcase
    end

    logic       w_legal, w_b_imm, w_has_rd, w_st, w_br;
    logic [3:0] w_ctl;

    always_comb begin
        w_legal  = 1'b0;
        w_ctl    = ILLEGAL_CTL;
        w_b_imm  = 1'b0;
        w_has_rd = 1'b0;
        w_st     = 1'b0;
        w_br     = 1'b0;
        unique case (1'b1)
            w_is_r: begin
                if (w_f7 == 7'b0000000 && w_f3_ok) begin
                    w_legal  = 1'b1;
                    w_ctl    = w_f3_ctl;
                    w_has_rd = 1'b1;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_legal  = 1'b1;
                    w_ctl    = 4'd6;
                    w_has_rd = 1'b1;
                end
            end
            w_is_i: begin
                if (w_f3_ok) begin
                    w_legal  = 1'b1;
                    w_ctl    = w_f3_ctl;
                    w_b_imm  = 1'b1;
                    w_has_rd = 1'b1;
                end
            end
            w_is_ld: begin
                w_legal  = 1'b1;
                w_ctl    = 4'd2;
                w_b_imm  = 1'b1;
                w_has_rd = 1'b1;
            end
            w_is_st: begin
                w_legal = 1'b1;
                w_ctl   = 4'd2;
                w_b_imm = 1'b1;
                w_st    = 1'b1;
            end
            w_is_br: begin
                if (w_f3[2:1] == 2'b00) begin
                    w_legal = 1'b1;
                    w_ctl   = 4'd6;
                    w_br    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] w_rs1_v;
    logic [XLEN-1:0] w_rs2_v;

`ifdef ALU_ISSUE_FORWARDING_EN
    // MEM result is younger than WB, so it wins; x0 is hardwired zero.
    always_comb begin
        w_rs1_v = id_rs1_data;
        if (w_rs1 != 5'd0 && fwd_mem_en && fwd_mem_rd == w_rs1)
            w_rs1_v = fwd_mem_data;
        else if (w_rs1 != 5'd0 && fwd_wb_en && fwd_wb_rd == w_rs1)
            w_rs1_v = fwd_wb_data;
    end

    always_comb begin
        w_rs2_v = id_rs2_data;
        if (w_rs2 != 5'd0 && fwd_mem_en && fwd_mem_rd == w_rs2)
            w_rs2_v = fwd_mem_data;
        else if (w_rs2 != 5'd0 && fwd_wb_en && fwd_wb_rd == w_rs2)
            w_rs2_v = fwd_wb_data;
    end
`else
    assign w_rs1_v = id_rs1_data;
    assign w_rs2_v = id_rs2_data;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_mem_en, fwd_wb_en, fwd_mem_rd, fwd_wb_rd,
                            fwd_mem_data, fwd_wb_data, w_rs1, w_rs2};
`endif

    logic [XLEN-1:0] w_a, w_b, w_sd;
    logic [4:0]      w_rd;

    assign w_a  = w_legal ? w_rs1_v : '0;
    assign w_b  = !w_legal ? '0 : (w_b_imm ? id_imm : w_rs2_v);
    assign w_sd = w_st ? w_rs2_v : '0;
    assign w_rd = w_has_rd ? id_instr[11:7] : 5'd0;

    logic            r_valid, r_br, r_ne, r_ill;
    logic [3:0]      r_ctl;
    logic [XLEN-1:0] r_a, r_b, r_sd;
    logic [4:0]      r_rd;

    always_ff @(posedge CLK) begin
        if (RST || flush || (!stall && !id_valid)) begin
            r_valid <= 1'b0;
            r_ctl   <= ILLEGAL_CTL;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= 5'd0;
            r_br    <= 1'b0;
            r_ne    <= 1'b0;
            r_sd    <= '0;
            r_ill   <= 1'b0;
        end else if (!stall) begin
            r_valid <= 1'b1;
            r_ctl   <= w_ctl;
            r_a     <= w_a;
            r_b     <= w_b;
            r_rd    <= w_rd;
            r_br    <= w_br;
            r_ne    <= w_br & w_f3[0];
            r_sd    <= w_sd;
            r_ill   <= !w_legal;
        end
    end

    assign ex.ex_valid      = r_valid;
    assign ex.ex_ALUctl     = r_ctl;
    assign ex.ex_A          = r_a;
    assign ex.ex_B          = r_b;
    assign ex.ex_rd         = r_rd;
    assign ex.ex_is_branch  = r_br;
    assign ex.ex_branch_ne  = r_ne;
    assign ex.ex_store_data = r_sd;
    assign ex.ex_illegal    = r_ill;
endmodule

// File: tb/tb_alu_issue.sv
// Directed + random bench for alu_issue against a field-level reference model.
// Forwarding expectations follow ALU_ISSUE_FORWARDING_EN like the DUT build.
module tb_alu_issue;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'h0;
    logic [31:0] id_rs1_data = 32'h0;
    logic [31:0] id_rs2_data = 32'h0;
    logic [31:0] id_imm = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        fwd_mem_en = 1'b0;
    logic        fwd_wb_en = 1'b0;
    logic [4:0]  fwd_mem_rd = 5'd0;
    logic [4:0]  fwd_wb_rd = 5'd0;
    logic [31:0] fwd_mem_data = 32'h0;
    logic [31:0] fwd_wb_data = 32'h0;

    int checks = 0;
    int errors = 0;

    alu_issue_if #(.XLEN(32)) ex ();

    alu_issue dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .stall(stall), .flush(flush),
        .fwd_mem_en(fwd_mem_en), .fwd_wb_en(fwd_wb_en),
        .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .ex(ex.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        br;
        logic        ne;
        logic [31:0] sd;
        logic        ill;
    } ex_t;

    ex_t exp_q;
    ex_t bub;

    function automatic ex_t bubble();
        ex_t t;
        t.v = 0; t.ctl = 4'd15; t.a = 0; t.b = 0; t.rd = 0;
        t.br = 0; t.ne = 0; t.sd = 0; t.ill = 0;
        return t;
    endfunction

    function automatic logic [31:0] src(logic [4:0] r, logic [31:0] rf);
`ifdef ALU_ISSUE_FORWARDING_EN
        if (r != 0 && fwd_mem_en && fwd_mem_rd == r) return fwd_mem_data;
        if (r != 0 && fwd_wb_en && fwd_wb_rd == r) return fwd_wb_data;
`endif
        return rf;
    endfunction

    function automatic ex_t model(logic [31:0] ins);
        int f3map[8] = '{2, -1, 7, -1, -1, -1, 1, 0};
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [31:0] a = src(ins[19:15], id_rs1_data);
        logic [31:0] b2 = src(ins[24:20], id_rs2_data);
        int code = -1;
        bit imm = 0, wr = 0, st = 0, br = 0;
        ex_t t = bubble();
        t.v = 1;
        case (op)
            7'h33: begin
                if (f7 == 0) code = f3map[f3];
                else if (f7 == 7'h20 && f3 == 0) code = 6;
                wr = 1;
            end
            7'h13: begin code = f3map[f3]; imm = 1; wr = 1; end
            7'h03: begin code = 2; imm = 1; wr = 1; end
            7'h23: begin code = 2; imm = 1; st = 1; end
            7'h63: if (f3 < 2) begin code = 6; br = 1; end
            default: ;
        endcase
        if (code < 0) begin
            t.ill = 1;
            return t;
        end
        t.ctl = 4'(code);
        t.a   = a;
        t.b   = imm ? id_imm : b2;
        t.rd  = wr ? ins[11:7] : 5'd0;
        t.br  = br;
        t.ne  = br && f3[0];
        t.sd  = st ? b2 : 32'h0;
        return t;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        ex_t nx;
        if (RST || flush) nx = bub;
        else if (stall) nx = exp_q;
        else if (id_valid) nx = model(id_instr);
        else nx = bub;
        @(posedge CLK);
        exp_q = nx;
        #1;
        check("valid", 32'(ex.ex_valid), 32'(exp_q.v));
        check("ctl", 32'(ex.ex_ALUctl), 32'(exp_q.ctl));
        check("A", ex.ex_A, exp_q.a);
        check("B", ex.ex_B, exp_q.b);
        check("rd", 32'(ex.ex_rd), 32'(exp_q.rd));
        check("is_branch", 32'(ex.ex_is_branch), 32'(exp_q.br));
        check("branch_ne", 32'(ex.ex_branch_ne), 32'(exp_q.ne));
        check("store_data", ex.ex_store_data, exp_q.sd);
        check("illegal", 32'(ex.ex_illegal), 32'(exp_q.ill));
    endtask

    function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] rs2,
            logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic issue(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2,
                         logic [31:0] im);
        id_valid = 1; id_instr = ins;
        id_rs1_data = r1; id_rs2_data = r2; id_imm = im;
    endtask

    initial begin
        bub = bubble();
        exp_q = bub;

        // reset held 2 cycles with a valid instruction present
        issue(enc(0, 2, 1, 0, 3, 7'h33), 5, 7, 0);
        RST = 1;
        step();
        step();
        check("rst_ctl", 32'(ex.ex_ALUctl), 32'd15);
        check("rst_valid", 32'(ex.ex_valid), 32'd0);
        RST = 0;

        // add x3,x1,x2
        step();
        check("add_ctl", 32'(ex.ex_ALUctl), 32'd2);
        check("add_A", ex.ex_A, 32'd5);
        check("add_B", ex.ex_B, 32'd7);
        check("add_rd", 32'(ex.ex_rd), 32'd3);

        issue(enc(7'h20, 2, 1, 0, 3, 7'h33), 9, 4, 0);
        step();
        check("sub_ctl", 32'(ex.ex_ALUctl), 32'd6);

        issue(enc(7'h7F, 5'h1F, 1, 3'b010, 4, 7'h13), 1, 0, 32'hFFFFFFFF);
        step();
        check("slti_ctl", 32'(ex.ex_ALUctl), 32'd7);
        check("slti_B", ex.ex_B, 32'hFFFFFFFF);

        issue(enc(0, 2, 1, 3'b001, 0, 7'h63), 3, 3, 0);
        step();
        check("bne_ctl", 32'(ex.ex_ALUctl), 32'd6);
        check("bne_br", 32'(ex.ex_is_branch), 32'd1);
        check("bne_ne", 32'(ex.ex_branch_ne), 32'd1);

        issue(32'h0000007F, 8, 9, 10);
        step();
        check("ill_flag", 32'(ex.ex_illegal), 32'd1);
        check("ill_ctl", 32'(ex.ex_ALUctl), 32'd15);
        check("ill_valid", 32'(ex.ex_valid), 32'd1);

        // forwarding priority
        issue(enc(0, 2, 1, 0, 5, 7'h33), 32'h99, 32'h3, 0);
        fwd_mem_en = 1; fwd_mem_rd = 1; fwd_mem_data = 32'h11;
        fwd_wb_en = 1;  fwd_wb_rd = 1;  fwd_wb_data = 32'h22;
        step();
`ifdef ALU_ISSUE_FORWARDING_EN
        check("fwd_prio", ex.ex_A, 32'h11);
`else
        check("nofwd_A", ex.ex_A, 32'h99);
`endif
        fwd_wb_en = 0;
        fwd_mem_data = 32'hAA;
        step();
`ifndef ALU_ISSUE_FORWARDING_EN
        check("nofwd_AA", ex.ex_A, 32'h99);
`endif
        issue(enc(0, 2, 0, 0, 5, 7'h33), 32'h1234, 32'h3, 0);
        fwd_mem_rd = 0;
        step();
        check("x0_nofwd", ex.ex_A, 32'h1234);
        fwd_mem_en = 0;

        // stall hold, stall+flush, release
        issue(enc(0, 2, 1, 3'b111, 6, 7'h33), 32'hF0, 32'h3C, 0);
        step();
        stall = 1;
        issue(enc(0, 2, 1, 3'b110, 7, 7'h33), 32'h1, 32'h2, 0);
        repeat (3) step();
        check("stall_ctl", 32'(ex.ex_ALUctl), 32'd0);
        check("stall_rd", 32'(ex.ex_rd), 32'd6);
        flush = 1;
        step();
        check("sf_valid", 32'(ex.ex_valid), 32'd0);
        stall = 0; flush = 0;
        step();
        check("rel_ctl", 32'(ex.ex_ALUctl), 32'd1);
        check("rel_rd", 32'(ex.ex_rd), 32'd7);

        // random stream
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            logic [6:0] f7;
            logic [2:0] f3;
            int k = $urandom_range(0, 9);
            f3 = 3'($urandom);
            f7 = 7'($urandom_range(0, 3) == 0 ? $urandom : 0);
            case (k)
                0, 1: op = 7'h33;
                2: begin op = 7'h33; f7 = 7'h20; end
                3, 4: op = 7'h13;
                5: op = 7'h03;
                6: op = 7'h23;
                7, 8: op = 7'h63;
                default: op = 7'($urandom);
            endcase
            issue(enc(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      f3, 5'($urandom), op), $urandom, $urandom, $urandom);
            id_valid = ($urandom_range(0, 7) != 0);
            fwd_mem_en = 1'($urandom); fwd_mem_rd = 5'($urandom_range(0, 3));
            fwd_wb_en = 1'($urandom);  fwd_wb_rd = 5'($urandom_range(0, 3));
            fwd_mem_data = $urandom; fwd_wb_data = $urandom;
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 11) == 0);
            RST = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
